sine_rom_reader: RTL and testbench

SINE_ROM_READER -- requirements
Module: sine_rom_reader

---
 rtl/sine_pkg.sv | 28 ++
 rtl/sine_bank.sv | 31 +++
 rtl/sine_rom_reader.sv | 96 +++++++++
 tb/tb_sine_rom_reader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sine_pkg.sv
// Shared constants, the sample type and the elaboration-time sine table generator
// used by the sine ROM reader.
package sine_pkg;

   localparam int unsigned NUM_BANKS  = 8;
   localparam int unsigned BANK_SEL_W = 3;
   localparam int unsigned SAMPLE_W   = 32;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   localparam real PI = 3.14159265358979323846;

   // round(sin(pi*ph/2**(addr_w-1)) * 2**(data_w-2)), symmetric about zero; data_w <= 32.
   function automatic logic [63:0] sine_word(input int unsigned ph, input int unsigned addr_w,
                                             input int unsigned data_w);
      real half;
      real scale;
      real val;
      half  = 1.0;
      scale = 1.0;
      for (int unsigned k = 0; k + 1 < addr_w; k++) half = half * 2.0;
      for (int unsigned k = 0; k + 2 < data_w; k++) scale = scale * 2.0;
      val = $sin((PI * real'(ph)) / half) * scale;
      if (val >= 0.0) return 64'($rtoi(val + 0.5));
      return -64'($rtoi(-val + 0.5));
   endfunction

endpackage

// File: rtl/sine_bank.sv
// One eighth of the sine table (bank BANK_NUM, 1..8) with a registered, enabled read port.
module sine_bank
   import sine_pkg::*;
#(
   parameter int unsigned BANK_NUM   = 1,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                             clk_i,
   input  logic                             en_i,
   input  logic [ADDR_WIDTH-BANK_SEL_W-1:0] index_i,
   output logic [DATA_WIDTH-1:0]            word_o
);

   localparam int unsigned Words = 2 ** (ADDR_WIDTH - BANK_SEL_W);

   logic [DATA_WIDTH-1:0] rom [Words];
   logic [DATA_WIDTH-1:0] word_q;

   // Segment contents are fixed at elaboration from the table generator.
   for (genvar i = 0; i < Words; i++) begin : g_rom
      assign rom[i] = DATA_WIDTH'(sine_word((BANK_NUM - 1) * Words + i, ADDR_WIDTH, DATA_WIDTH));
   end

   always_ff @(posedge clk_i) begin
      if (en_i) word_q <= rom[index_i];
   end

   assign word_o = word_q;

endmodule

// File: rtl/sine_rom_reader.sv
// Three-stage stallable sine lookup: phase split, eight-bank read, bank select.
module sine_rom_reader
   import sine_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  phase_valid,
   input  logic [ADDR_WIDTH-1:0] phase,
   output logic                  phase_ready,
   output logic                  sample_valid,
   output logic [DATA_WIDTH-1:0] sample,
   input  logic                  sample_ready,
   output logic [15:0]           sample_count
);

   localparam int unsigned IdxW = ADDR_WIDTH - BANK_SEL_W;

   logic                  stall;
   logic                  s1_valid_q, s1_valid_d;
   logic [BANK_SEL_W-1:0] s1_bank_q, s1_bank_d;
   logic [IdxW-1:0]       s1_index_q, s1_index_d;
   logic                  s2_valid_q, s2_valid_d;
   logic [BANK_SEL_W-1:0] s2_bank_q, s2_bank_d;
   logic                  s3_valid_q, s3_valid_d;
   logic [DATA_WIDTH-1:0] sample_q, sample_d;
   logic [15:0]           count_q, count_d;
   logic [DATA_WIDTH-1:0] bank_word [NUM_BANKS];

   assign stall       = s3_valid_q & ~sample_ready;
   assign phase_ready = ~stall;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      sine_bank #(
         .BANK_NUM   (b + 1),
         .ADDR_WIDTH (ADDR_WIDTH),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
         .clk_i   (clk),
         .en_i    (~stall),
         .index_i (s1_index_q),
         .word_o  (bank_word[b])
      );
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_bank_d  = s1_bank_q;
      s1_index_d = s1_index_q;
      s2_valid_d = s2_valid_q;
      s2_bank_d  = s2_bank_q;
      s3_valid_d = s3_valid_q;
      sample_d   = sample_q;
      count_d    = count_q;
      // Bubbles advance like data; sample only changes when a real word arrives.
      if (!stall) begin
         s1_valid_d = phase_valid;
         s1_bank_d  = phase[ADDR_WIDTH-1 -: BANK_SEL_W];
         s1_index_d = phase[IdxW-1:0];
         s2_valid_d = s1_valid_q;
         s2_bank_d  = s1_bank_q;
         s3_valid_d = s2_valid_q;
         if (s2_valid_q) sample_d = bank_word[s2_bank_q];
      end
      if (s3_valid_q && sample_ready) count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_bank_q  <= '0;
         s1_index_q <= '0;
         s2_valid_q <= 1'b0;
         s2_bank_q  <= '0;
         s3_valid_q <= 1'b0;
         sample_q   <= '0;
         count_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_bank_q  <= s1_bank_d;
         s1_index_q <= s1_index_d;
         s2_valid_q <= s2_valid_d;
         s2_bank_q  <= s2_bank_d;
         s3_valid_q <= s3_valid_d;
         sample_q   <= sample_d;
         count_q    <= count_d;
      end
   end

   assign sample_valid = s3_valid_q;
   assign sample       = sample_q;
   assign sample_count = count_q;

endmodule

// File: tb/tb_sine_rom_reader.sv
// Scoreboard bench for sine_rom_reader: stimulus pushes expected samples, a monitor pops them.
module tb_sine_rom_reader;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;
   localparam real PI = 3.14159265358979323846;

   logic          clk = 1'b0;
   logic          reset;
   logic          phase_valid;
   logic [AW-1:0] phase;
   logic          phase_ready;
   logic          sample_valid;
   logic [DW-1:0] sample;
   logic          sample_ready;
   logic [15:0]   sample_count;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            n_acc    = 0;
   logic [DW-1:0] exp_q [$];
   bit            auto_push = 1'b1;
   bit            mon_en    = 1'b0;
   bit            accepted;
   bit            holding   = 1'b0;
   logic [AW-1:0] cur_phase = '0;
   bit            stall_prev = 1'b0;
   logic [DW-1:0] held;
   logic [AW-1:0] dir_ph [4];
   logic [DW-1:0] dir_ex [4];

   always #5 clk = ~clk;

   sine_rom_reader #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .phase_valid  (phase_valid),
      .phase        (phase),
      .phase_ready  (phase_ready),
      .sample_valid (sample_valid),
      .sample       (sample),
      .sample_ready (sample_ready),
      .sample_count (sample_count)
   );

   // Reference: round(sin(pi*ph/512) * 2**30), rounded half away from zero.
   function automatic logic [DW-1:0] ref_sine(input int unsigned ph);
      real v;
      v = $sin((PI * real'(ph)) / 512.0) * 1073741824.0;
      if (v >= 0.0) return DW'($rtoi(v + 0.5));
      return -DW'($rtoi(-v + 0.5));
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: note acceptance just before the edge, return 1 time unit after it.
   task automatic step();
      @(negedge clk);
      accepted = phase_valid && phase_ready && !reset;
      if (accepted && auto_push) begin
         exp_q.push_back(ref_sine(int'(phase)));
         n_acc++;
      end
      @(posedge clk);
      #1;
   endtask

   // Upstream model: a phase once offered is re-offered until it is accepted.
   task automatic drive(input bit v);
      if (!holding) cur_phase = AW'($urandom_range(0, 1023));
      phase_valid = v;
      phase       = cur_phase;
      step();
      holding = !accepted && (v || holding);
   endtask

   task automatic drain();
      phase_valid  = 1'b0;
      sample_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic directed();
      auto_push    = 1'b0;
      sample_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         phase_valid = (k < 4);
         phase       = (k < 4) ? dir_ph[k] : '0;
         if (k < 4) exp_q.push_back(dir_ex[k]);
         step();
         check("lat_valid", sample_valid, (k >= 2 && k <= 5));
         if (k >= 2 && k <= 5) check("lat_sample", sample, dir_ex[k-2]);
      end
      auto_push = 1'b1;
   endtask

   always @(negedge clk) begin
      if (mon_en && !reset) begin
         check("phase_ready", phase_ready, !(sample_valid && !sample_ready));
         if (stall_prev) begin
            check("stall_valid_held", sample_valid, 1);
            check("stall_sample_stable", sample, held);
         end
         if (sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_sample: got 0x%0h, expected none (t=%0t)", sample, $time);
            end else begin
               check("sample", sample, exp_q.pop_front());
            end
         end
         stall_prev = sample_valid && !sample_ready;
         held       = sample;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [AW-1:0] cnt;
      reset        = 1'b1;
      phase_valid  = 1'b0;
      phase        = '0;
      sample_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_sample_valid", sample_valid, 0);
      check("rst_sample", sample, 0);
      check("rst_count", sample_count, 0);
      check("rst_phase_ready", phase_ready, 1);
      reset  = 1'b0;
      mon_en = 1'b1;

      // Quarter-period points, back to back.
      dir_ph = '{10'd0, 10'd256, 10'd512, 10'd768};
      dir_ex = '{32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 32'hC000_0000};
      directed();
      check("count_after_4", sample_count, 4);

      // Eighth-period points and the bank 4 -> 5 boundary.
      dir_ph = '{10'd128, 10'd640, 10'd511, 10'd512};
      dir_ex = '{32'h2D41_3CCD, 32'hD2BE_C333, ref_sine(511), 32'h0000_0000};
      directed();
      check("count_after_8", sample_count, 8);

      // Reset with three samples in flight.
      sample_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         phase_valid = 1'b1;
         phase       = AW'($urandom_range(0, 1023));
         step();
      end
      phase_valid  = 1'b0;
      sample_ready = 1'b0;
      check("pre_reset_valid", sample_valid, 1);
      reset = 1'b1;
      #1;
      check("async_rst_valid", sample_valid, 0);
      check("async_rst_count", sample_count, 0);
      check("async_rst_sample", sample, 0);
      check("async_rst_ready", phase_ready, 1);
      exp_q.delete();
      n_acc = 0;
      @(posedge clk);
      #1;
      reset        = 1'b0;
      sample_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         check("post_reset_no_stale", sample_valid, 0);
      end

      // Free-running phase counter over two full periods.
      cnt = '0;
      for (int i = 0; i < 2048; i++) begin
         phase_valid = 1'b1;
         phase       = cnt;
         step();
         if (accepted) cnt = cnt + 1'b1;
      end
      check("count_sweep", sample_count, 2045);
      drain();

      // Ten-cycle backpressure with a full pipe.
      holding      = 1'b0;
      sample_ready = 1'b1;
      for (int k = 0; k < 3; k++) drive(1'b1);
      sample_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #1;
         check("stall_phase_ready", phase_ready, 0);
         drive(1'b1);
      end
      sample_ready = 1'b1;
      for (int k = 0; k < 4; k++) drive(1'b1);
      drain();
      holding = 1'b0;

      // Toggling valid with random backpressure.
      for (int i = 0; i < 400; i++) begin
         sample_ready = 1'($urandom_range(0, 1));
         drive(i % 2 == 0);
      end
      drain();
      check("final_count", sample_count, 16'(n_acc));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
